// File: rtl/mux_4x1_pkg.sv
// mux_4x1_pkg -- shared constants for the 4:1 multiplexer slice.
//   SEL_A..SEL_D  : select codes choosing inputs a..d
//   DEFAULT_WIDTH : default data width of the mux
package mux_4x1_pkg;

   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;

   localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/mux_4x1_core.sv
// mux_4x1_core -- purely combinational 4:1 selector.
// Ports:
//   a, b, c, d : WIDTH-bit data inputs
//   sel        : 2-bit select code (SEL_A..SEL_D)
//   y          : WIDTH-bit selected input, zero latency
module mux_4x1_core
   import mux_4x1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = a;
      case (sel)
         SEL_A:   y = a;
         SEL_B:   y = b;
         SEL_C:   y = c;
         SEL_D:   y = d;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/mux_4x1.sv
// mux_4x1 -- 4:1 multiplexer with a combinational and a registered output.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (clears y_q, valid_q, last_sel)
//   a..d     : WIDTH-bit data inputs
//   sel      : select code
//   en       : capture enable for the registered path
//   y        : combinational mux result, unaffected by rst
//   y_q      : registered mux result, one cycle latency
//   valid_q  : high for the cycle after an enabled capture. It is a status
//              flag, not a handshake: there is no ready, and the consumer
//              samples y_q whenever valid_q is high.
//   last_sel : select code of the last capture (only with MUX_4X1_HIST_EN)
// Configuration macro: MUX_4X1_HIST_EN adds the last_sel port and register.
module mux_4x1
   import mux_4x1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       sel,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             valid_q
`ifdef MUX_4X1_HIST_EN
   ,
   output logic [1:0]       last_sel
`endif
);

   mux_4x1_core #(.WIDTH(WIDTH)) u_core (
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .sel (sel),
      .y   (y)
   );

   // y_q holds across disabled edges; valid_q only marks the edge right
   // after a capture, so it drops on any disabled edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= en;
         if (en) begin
            y_q <= y;
         end
      end
   end

`ifdef MUX_4X1_HIST_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         last_sel <= SEL_A;
      end else if (en) begin
         last_sel <= sel;
      end
   end
`endif

endmodule

// File: tb/tb_mux_4x1.sv
module tb_mux_4x1;

   localparam int WIDTH = 8;
   localparam int W     = WIDTH + 3;   // packed {valid, last_sel, y_q}

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] a, b, c, d;
   logic [1:0]       sel;
   logic             en;
   logic [WIDTH-1:0] y, y_q;
   logic             valid_q;
   logic [1:0]       last_sel_obs;
`ifdef MUX_4X1_HIST_EN
   logic [1:0]       last_sel;
   assign last_sel_obs = last_sel;
`else
   assign last_sel_obs = 2'b00;
`endif

   // clock / reset block
   always #5 clk = ~clk;

   mux_4x1 #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .sel      (sel),
      .en       (en),
      .y        (y),
      .y_q      (y_q),
      .valid_q  (valid_q)
`ifdef MUX_4X1_HIST_EN
      ,
      .last_sel (last_sel)
`endif
   );

   // scoreboard state
   int               n_cmp = 0;
   int               n_err = 0;
   logic [W-1:0]     exp_q[$];
   logic [WIDTH-1:0] m_yq    = '0;
   logic             m_valid = 1'b0;
   logic [1:0]       m_last  = 2'b00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // reference: the inputs are an array indexed by the select code
   function automatic logic [WIDTH-1:0] ref_mux(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                                input logic [WIDTH-1:0] vc, input logic [WIDTH-1:0] vd,
                                                input logic [1:0] s);
      logic [WIDTH-1:0] v[4];
      v[0] = va; v[1] = vb; v[2] = vc; v[3] = vd;
      return v[s];
   endfunction

   // driver: apply inputs (called just after a falling edge)
   task automatic drive(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic [WIDTH-1:0] vc, input logic [WIDTH-1:0] vd,
                        input logic [1:0] s, input logic e, input logic r);
      a = va; b = vb; c = vc; d = vd; sel = s; en = e; rst = r;
   endtask

   // one clock: check y and held outputs, update model, clock, check registers
   task automatic step(input string tag);
      logic [W-1:0] got;
      logic [W-1:0] expv;
      #1;
      check({tag, "_y"}, 32'(y), 32'(ref_mux(a, b, c, d, sel)));
      check({tag, "_hold"}, 32'(y_q), 32'(m_yq));
      if (rst) begin
         m_yq = '0; m_valid = 1'b0; m_last = 2'b00;
      end else begin
         m_valid = en;
         if (en) begin
            m_yq   = ref_mux(a, b, c, d, sel);
            m_last = sel;
         end
      end
      exp_q.push_back({m_valid, m_last, m_yq});
      @(posedge clk);
      #1;
      got  = {valid_q, last_sel_obs, y_q};
      expv = exp_q.pop_front();
      check({tag, "_yq"}, 32'(got[WIDTH-1:0]), 32'(expv[WIDTH-1:0]));
      check({tag, "_valid"}, 32'(got[W-1]), 32'(expv[W-1]));
`ifdef MUX_4X1_HIST_EN
      check({tag, "_last"}, 32'(got[W-2:WIDTH]), 32'(expv[W-2:WIDTH]));
`endif
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] pat[4];
      pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h0F; pat[3] = 8'hF0;

      @(negedge clk);
      // reset state
      drive('0, '0, '0, '0, 2'b00, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("reset_yq", 32'(y_q), 32'h0);
      check("reset_valid", 32'(valid_q), 32'h0);
      @(negedge clk);
      step("rst_hold");

      // 0/1 pattern across all selects
      for (int i = 0; i < 4; i++) begin
         drive(8'd0, 8'd1, 8'd0, 8'd1, 2'(i), 1'b0, 1'b0);
         #1 check("pat01_y", 32'(y), (i % 2 == 1) ? 32'd1 : 32'd0);
         #9;
      end
      @(negedge clk);

      // non-selected inputs toggling must not move y
      drive(8'd0, 8'd1, 8'd0, 8'd0, 2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         a = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
         #1 check("nonsel_y", 32'(y), 32'd1);
      end
      @(negedge clk);

      // wide pattern, each select, captured
      for (int i = 0; i < 4; i++) begin
         drive(pat[0], pat[1], pat[2], pat[3], 2'(i), 1'b1, 1'b0);
         step("wide");
      end

      // capture on sel=11 then hold with en=0
      drive(8'h00, 8'h00, 8'h00, 8'h01, 2'b11, 1'b1, 1'b0);
      step("cap_d");
      drive(8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0);
      step("hold_d");

      // reset beats enable; y keeps tracking
      drive(8'h00, 8'h01, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0);
      step("pre_rst");
      drive(8'h00, 8'h01, 8'h00, 8'h00, 2'b01, 1'b1, 1'b1);
      step("rst_pri");
      drive(8'h00, 8'h77, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0);
      step("post_rst");

`ifdef MUX_4X1_HIST_EN
      drive(8'h00, 8'h00, 8'h5A, 8'h00, 2'b10, 1'b1, 1'b0);
      step("hist_c");
      drive(8'h00, 8'h00, 8'h5A, 8'h00, 2'b10, 1'b1, 1'b1);
      step("hist_rst");
`endif

      // random traffic, with mid-cycle input changes before some edges
      for (int i = 0; i < 300; i++) begin
         drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            #2;
            a = 8'($urandom); d = 8'($urandom); sel = 2'($urandom_range(0, 3));
         end
         step("rand");
      end

      if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mux_4x1.md
MUX_4X1 -- requirements
Module: mux_4x1

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of each data input and of every data output.
REQ-002 Port: clk  input  1  single clock; all sequential logic samples on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: a  input  WIDTH  data input selected when sel = 2'b00.
REQ-005 Port: b  input  WIDTH  data input selected when sel = 2'b01.
REQ-006 Port: c  input  WIDTH  data input selected when sel = 2'b10.
REQ-007 Port: d  input  WIDTH  data input selected when sel = 2'b11.
REQ-008 Port: sel  input  2  select code.
REQ-009 Port: en  input  1  capture enable for the registered path.
REQ-010 Port: y  output  WIDTH  combinational mux result.
REQ-011 Port: y_q  output  WIDTH  registered mux result.
REQ-012 Port: valid_q  output  1  y_q holds a result captured in the previous cycle.
REQ-013 Port: last_sel  output  2  select code of the last capture; present only with MUX_4X1_HIST_EN.

Function
REQ-014 y SHALL equal a, b, c or d for sel = 00, 01, 10, 11 respectively, with zero latency and no clock dependency.
REQ-015 y SHALL update within the same delta cycle as any change on sel or the selected input.
REQ-016 y SHALL NOT change when a non-selected input changes.
REQ-017 On a rising clk edge with rst = 0 and en = 1, y_q SHALL load the current y, and valid_q SHALL go to 1.
REQ-018 On a rising clk edge with rst = 0 and en = 0, y_q SHALL hold its value, and valid_q SHALL go to 0.
REQ-019 Latency from inputs to y_q SHALL be exactly one clk cycle.
REQ-020 Each bit of a WIDTH > 1 vector SHALL be selected identically, with no bit reordering or extension.
REQ-021 Input changes between clock edges SHALL NOT affect y_q until the next enabled edge.

Reset
REQ-022 When rst = 1 at a rising clk edge, the edge SHALL set y_q to 0, valid_q to 0 and last_sel (if present) to 2'b00.
REQ-023 rst SHALL take priority over en.
REQ-024 y SHALL remain purely combinational and SHALL NOT be affected by rst.
REQ-025 The first enabled edge after rst deasserts SHALL capture normally.

Configuration
REQ-026 With macro MUX_4X1_HIST_EN defined, the last_sel port and register SHALL exist and SHALL load sel on every enabled, non-reset edge.
REQ-027 With MUX_4X1_HIST_EN undefined, the last_sel port and register SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package mux_4x1_pkg SHALL hold the select constants SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10, SEL_D = 2'b11 and the default WIDTH.
REQ-029 The combinational selection SHALL be a sub-module mux_4x1_core (ports a, b, c, d, sel, y; parameter WIDTH).
REQ-030 The top level SHALL instantiate mux_4x1_core and add only the output registers.

Verification
REQ-031 With a=0, b=1, c=0, d=1, stepping sel 00, 01, 10, 11 at 10-unit intervals -> y = 0, 1, 0, 1.
REQ-032 With sel = 01 and b = 1 held, toggling a, c and d -> y stays 1 throughout.
REQ-033 rst = 1 for one edge after y_q = 1 -> y_q = 0, valid_q = 0, while y still tracks the inputs.
REQ-034 With en = 1, sel = 11 and d = 1 at edge N -> y_q = 1 and valid_q = 1 after edge N; then en = 0 and d = 0 at edge N+1 -> y_q holds 1 and valid_q = 0.
REQ-035 With WIDTH = 8, a = 8'hA5, b = 8'h3C, c = 8'h0F, d = 8'hF0, stepping sel through all four codes -> y matches each selected input exactly.
REQ-036 With MUX_4X1_HIST_EN defined, an enabled edge with sel = 10 -> last_sel = 2'b10; a subsequent rst edge -> last_sel = 2'b00.
